// File: rtl/age_pick_postcoder_if.sv
// Handshake bundle for the age-ordered picker: set/flush/head inputs and the
// registered pick output plus occupancy status.
interface age_pick_postcoder_if #(
   parameter int unsigned WIDTH = 5
);
   localparam int unsigned DEPTH = 1 << WIDTH;

   logic             flush_i;
   logic [WIDTH-1:0] head_i;
   logic             set_valid_i;
   logic [WIDTH-1:0] set_idx_i;
   logic             pick_valid_o;
   logic [WIDTH-1:0] pick_idx_o;
   logic             pick_ready_i;
   logic [DEPTH-1:0] pending_o;
   logic [WIDTH:0]   count_o;

   modport master (
      output flush_i,
      output head_i,
      output set_valid_i,
      output set_idx_i,
      output pick_ready_i,
      input  pick_valid_o,
      input  pick_idx_o,
      input  pending_o,
      input  count_o
   );

   modport slave (
      input  flush_i,
      input  head_i,
      input  set_valid_i,
      input  set_idx_i,
      input  pick_ready_i,
      output pick_valid_o,
      output pick_idx_o,
      output pending_o,
      output count_o
   );
endinterface

// File: rtl/age_pick_postcoder.sv
// Age-ordered picker: rotates the pending mask by head, selects the oldest slot and
// post-codes it back to a physical index behind a registered valid/ready output.
module age_pick_postcoder #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 1 << WIDTH
) (
   input logic                clk,
   input logic                rst_n,
   age_pick_postcoder_if.slave bus
);

   logic [DEPTH-1:0] pending_q, pending_d;
   logic [DEPTH-1:0] rot;
   logic             pick_valid_q, pick_valid_d;
   logic [WIDTH-1:0] pick_idx_q, pick_idx_d;
   logic [WIDTH-1:0] sel_k;
   logic [WIDTH-1:0] phys;
   logic [WIDTH:0]   pop;
   logic             cand;
   logic             accept;
   logic             load;
   logic             set_ok;

   // Position k of the rotated view is the k-th oldest slot; index wraps naturally.
   always_comb begin
      rot = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         rot[k] = pending_q[bus.head_i + WIDTH'(k)];
      end
   end

   // Descending scan so the lowest set position is the last one written.
   always_comb begin
      sel_k = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sel_k = WIDTH'(k);
         end
      end
   end

   assign phys   = sel_k + bus.head_i;
   assign cand   = |pending_q;
   assign accept = pick_valid_q && bus.pick_ready_i;
   assign load   = cand && (!pick_valid_q || bus.pick_ready_i);

   // A set aimed at the slot still held in the output register is already in flight.
   assign set_ok = bus.set_valid_i &&
                   !(pick_valid_q && !bus.pick_ready_i && (bus.set_idx_i == pick_idx_q));

   always_comb begin
      pending_d    = pending_q;
      pick_valid_d = pick_valid_q;
      pick_idx_d   = pick_idx_q;
      if (bus.flush_i) begin
         pending_d    = '0;
         pick_valid_d = 1'b0;
      end else begin
         if (set_ok) begin
            pending_d[bus.set_idx_i] = 1'b1;
         end
         if (load) begin
            pending_d[phys] = 1'b0;
            pick_valid_d    = 1'b1;
            pick_idx_d      = phys;
         end else if (accept) begin
            pick_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q    <= '0;
         pick_valid_q <= 1'b0;
         pick_idx_q   <= '0;
      end else begin
         pending_q    <= pending_d;
         pick_valid_q <= pick_valid_d;
         pick_idx_q   <= pick_idx_d;
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         pop = pop + (WIDTH + 1)'(pending_q[i]);
      end
   end

   assign bus.pick_valid_o = pick_valid_q;
   assign bus.pick_idx_o   = pick_idx_q;
   assign bus.pending_o    = pending_q;
   assign bus.count_o      = pop + (WIDTH + 1)'(pick_valid_q);

endmodule

// File: tb/tb_age_pick_postcoder.sv
// Randomized and directed bench for age_pick_postcoder with a queue-based scoreboard
// fed by an age-order reference model.
module tb_age_pick_postcoder;
   localparam int unsigned WIDTH = 5;
   localparam int unsigned DEPTH = 1 << WIDTH;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   age_pick_postcoder_if #(.WIDTH(WIDTH)) bus ();

   age_pick_postcoder #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DEPTH-1:0] m_pend;
   logic             m_valid;
   logic [WIDTH-1:0] m_idx;
   int               exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int idx);
      bus.set_valid_i = 1'b1;
      bus.set_idx_i   = WIDTH'(idx);
   endtask

   // Reference: the oldest pending slot is the first one met walking forward from head.
   task automatic model_edge();
      logic [DEPTH-1:0] old;
      int               head;
      int               phys;
      bit               load;
      old  = m_pend;
      head = int'(bus.head_i);
      phys = -1;
      for (int d = 0; d < int'(DEPTH); d++) begin
         int s;
         s = (head + d) % int'(DEPTH);
         if (phys < 0 && old[s]) phys = s;
      end
      if (bus.flush_i) begin
         if (m_valid && !bus.pick_ready_i && exp_q.size() > 0) void'(exp_q.pop_back());
         m_pend  = '0;
         m_valid = 1'b0;
      end else begin
         load = (phys >= 0) && (!m_valid || bus.pick_ready_i);
         if (bus.set_valid_i &&
             !(m_valid && !bus.pick_ready_i && bus.set_idx_i == m_idx)) begin
            m_pend[bus.set_idx_i] = 1'b1;
         end
         if (load) begin
            m_pend[phys] = 1'b0;
            m_idx        = WIDTH'(phys);
            m_valid      = 1'b1;
            exp_q.push_back(phys);
         end else if (m_valid && bus.pick_ready_i) begin
            m_valid = 1'b0;
         end
      end
   endtask

   initial begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_idx   = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_pend  = '0;
            m_valid = 1'b0;
            m_idx   = '0;
            exp_q.delete();
         end else begin
            model_edge();
         end
      end
   end

   // Monitor: state compare every cycle, scoreboard pop on each accepted pick.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("mon_valid", 64'(bus.pick_valid_o), 64'(m_valid));
            check("mon_idx", 64'(bus.pick_idx_o), 64'(m_idx));
            check("mon_pending", 64'(bus.pending_o), 64'(m_pend));
            check("mon_count", 64'(bus.count_o), 64'($countones(m_pend)) + 64'(m_valid));
            if (bus.pick_valid_o && bus.pick_ready_i) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL accept_unexpected: got idx %0d expected no pick at %0t",
                           bus.pick_idx_o, $time);
               end else begin
                  int e;
                  e = exp_q.pop_front();
                  check("accept_idx", 64'(bus.pick_idx_o), 64'(e));
               end
            end
         end
      end
   end

   initial begin
      bus.flush_i      = 1'b0;
      bus.head_i       = '0;
      bus.set_valid_i  = 1'b0;
      bus.set_idx_i    = '0;
      bus.pick_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(bus.pick_valid_o), 64'd0);
      check("rst_idx", 64'(bus.pick_idx_o), 64'd0);
      check("rst_count", 64'(bus.count_o), 64'd0);
      check("rst_pending", 64'(bus.pending_o), 64'd0);
      rst_n = 1'b1;

      // Latency: no bypass from set to pick.
      set_slot(7);
      step();
      bus.set_valid_i = 1'b0;
      check("lat_pending1", 64'(bus.pending_o), 64'h80);
      check("lat_count1", 64'(bus.count_o), 64'd1);
      check("lat_valid1", 64'(bus.pick_valid_o), 64'd0);
      step();
      check("lat_valid2", 64'(bus.pick_valid_o), 64'd1);
      check("lat_idx2", 64'(bus.pick_idx_o), 64'd7);
      check("lat_pending2", 64'(bus.pending_o), 64'd0);
      check("lat_count2", 64'(bus.count_o), 64'd1);
      bus.pick_ready_i = 1'b1;
      step();
      bus.pick_ready_i = 1'b0;
      check("lat_drained", 64'(bus.count_o), 64'd0);

      // Wrap ordering with head 30 behind a held blocker.
      bus.head_i = 5'd30;
      set_slot(20);
      step();
      set_slot(1);
      step();
      set_slot(31);
      step();
      set_slot(5);
      step();
      bus.set_valid_i = 1'b0;
      check("wrap_hold", 64'(bus.pick_idx_o), 64'd20);
      check("wrap_count", 64'(bus.count_o), 64'd4);
      bus.pick_ready_i = 1'b1;
      step();
      check("wrap_p0", 64'(bus.pick_idx_o), 64'd31);
      step();
      check("wrap_p1", 64'(bus.pick_idx_o), 64'd1);
      step();
      check("wrap_p2", 64'(bus.pick_idx_o), 64'd5);
      step();
      check("wrap_done", 64'(bus.pick_valid_o), 64'd0);
      bus.pick_ready_i = 1'b0;

      // Backpressure: held output survives head changes.
      bus.head_i = 5'd0;
      set_slot(3);
      step();
      set_slot(4);
      step();
      bus.set_valid_i = 1'b0;
      bus.head_i      = 5'd4;
      repeat (5) begin
         step();
         check("bp_hold", 64'(bus.pick_idx_o), 64'd3);
      end
      bus.pick_ready_i = 1'b1;
      step();
      check("bp_next", 64'(bus.pick_idx_o), 64'd4);
      check("bp_next_v", 64'(bus.pick_valid_o), 64'd1);
      step();
      check("bp_done", 64'(bus.pick_valid_o), 64'd0);
      bus.pick_ready_i = 1'b0;

      // Collision with the output register.
      set_slot(9);
      step();
      bus.set_valid_i = 1'b0;
      step();
      check("col_idx", 64'(bus.pick_idx_o), 64'd9);
      set_slot(9);
      step();
      check("col_ign_count", 64'(bus.count_o), 64'd1);
      check("col_ign_pend", 64'(bus.pending_o), 64'd0);
      bus.pick_ready_i = 1'b1;
      step();
      bus.set_valid_i  = 1'b0;
      bus.pick_ready_i = 1'b0;
      check("col_acc_valid", 64'(bus.pick_valid_o), 64'd0);
      check("col_acc_pend", 64'(bus.pending_o), 64'h200);
      step();
      check("col_repick_v", 64'(bus.pick_valid_o), 64'd1);
      check("col_repick", 64'(bus.pick_idx_o), 64'd9);
      bus.pick_ready_i = 1'b1;
      step();
      bus.pick_ready_i = 1'b0;

      // Full window, then flush overriding a same-cycle set.
      bus.head_i = 5'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         set_slot(i);
         step();
      end
      bus.set_valid_i = 1'b0;
      check("full_count", 64'(bus.count_o), 64'd32);
      check("full_pend", 64'(bus.pending_o), 64'hFFFF_FFFE);
      bus.flush_i = 1'b1;
      set_slot(0);
      step();
      bus.flush_i     = 1'b0;
      bus.set_valid_i = 1'b0;
      check("flush_pend", 64'(bus.pending_o), 64'd0);
      check("flush_valid", 64'(bus.pick_valid_o), 64'd0);
      check("flush_count", 64'(bus.count_o), 64'd0);

      // Asynchronous reset in the middle of a pick burst.
      bus.pick_ready_i = 1'b1;
      set_slot(2);
      step();
      set_slot(12);
      step();
      set_slot(22);
      step();
      bus.set_valid_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(bus.pick_valid_o), 64'd0);
      check("arst_idx", 64'(bus.pick_idx_o), 64'd0);
      check("arst_count", 64'(bus.count_o), 64'd0);
      check("arst_pend", 64'(bus.pending_o), 64'd0);
      #3 rst_n = 1'b1;
      repeat (4) begin
         step();
         check("arst_nopick", 64'(bus.pick_valid_o), 64'd0);
      end

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         bus.head_i       = WIDTH'($urandom);
         bus.set_valid_i  = 1'($urandom_range(0, 1));
         bus.set_idx_i    = WIDTH'($urandom);
         bus.pick_ready_i = ($urandom_range(0, 9) < 6);
         bus.flush_i      = ($urandom_range(0, 49) == 0);
         step();
      end

      bus.set_valid_i  = 1'b0;
      bus.flush_i      = 1'b0;
      bus.pick_ready_i = 1'b1;
      repeat (40) step();
      check("drain_valid", 64'(bus.pick_valid_o), 64'd0);
      check("drain_count", 64'(bus.count_o), 64'd0);
      check("drain_queue", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
